// File: rtl/csa_result_accumulator_if.sv
// csa_result_accumulator_if: sample-in / total-out handshake bundle for the accumulator
//   master drives start, in_valid, Sum, Cout, out_ready
//   slave  drives in_ready, acc_out, overflow, sample_cnt, out_valid, busy
interface csa_result_accumulator_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [39:0]      Sum;
    logic             Cout;
    logic [39:0]      acc_out;
    logic             overflow;
    logic [CNT_W-1:0] sample_cnt;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    modport master (
        output start, in_valid, Sum, Cout, out_ready,
        input  in_ready, acc_out, overflow, sample_cnt, out_valid, busy
    );
    modport slave (
        input  start, in_valid, Sum, Cout, out_ready,
        output in_ready, acc_out, overflow, sample_cnt, out_valid, busy
    );
endinterface

// File: rtl/csa_result_accumulator.sv
// csa_result_accumulator: sums N_SAMPLES 33-bit {Cout, Sum[31:0]} samples into a 40-bit total
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of csa_result_accumulator_if (sample handshake, total handshake, status)
module csa_result_accumulator #(
    parameter int N_SAMPLES = 16,
    parameter int CNT_W     = 8
) (
    input logic                     clk,
    input logic                     rst,
    csa_result_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);
    state_t           state_q, state_d;
    logic [39:0]      acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [40:0]      sample, sum_ext;
    logic             clear;
    logic             unused_sum_hi;
    // The adder's headroom byte carries no information for this consumer.
    assign unused_sum_hi  = ^bus.Sum[39:32];
    // A start in ACCUM restarts the run, so the concurrent beat must be refused.
    assign bus.in_ready   = state_q == ACCUM && !bus.start && !rst;
    assign bus.out_valid  = state_q == DONE;
    assign bus.acc_out    = acc_q;
    assign bus.overflow   = ovf_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.busy       = busy_q;
    always_comb begin
        sample  = {8'd0, bus.Cout, bus.Sum[31:0]};
        sum_ext = {1'b0, acc_q} + sample;
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                clear   = bus.start;
                state_d = bus.start ? ACCUM : IDLE;
            end
            ACCUM: begin
                clear = bus.start;
                if (!bus.start && bus.in_valid) begin
                    acc_d   = sum_ext[39:0];
                    ovf_d   = ovf_q | sum_ext[40];
                    cnt_d   = cnt_q + 1'b1;
                    state_d = cnt_q == LAST ? DONE : ACCUM;
                end
            end
            DONE: begin
                // A start is only honoured together with the output handshake.
                clear   = bus.out_ready && bus.start;
                state_d = !bus.out_ready ? DONE : bus.start ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end
        busy_d = state_d == ACCUM;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_csa_result_accumulator.sv
// tb_csa_result_accumulator: vector table plus model-checked random runs on N=4 and N=256 instances
module tb_csa_result_accumulator;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, cout, out_ready;
    logic [39:0] sum;
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    csa_result_accumulator_if #(.CNT_W(8)) b4 ();
    csa_result_accumulator_if #(.CNT_W(9)) b256 ();
    assign b4.start       = start;
    assign b4.in_valid    = in_valid;
    assign b4.Sum         = sum;
    assign b4.Cout        = cout;
    assign b4.out_ready   = out_ready;
    assign b256.start     = start;
    assign b256.in_valid  = in_valid;
    assign b256.Sum       = sum;
    assign b256.Cout      = cout;
    assign b256.out_ready = out_ready;
    csa_result_accumulator #(.N_SAMPLES(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    csa_result_accumulator #(.N_SAMPLES(256), .CNT_W(9)) dut256 (.clk(clk), .rst(rst), .bus(b256));

    typedef struct {
        logic        rst, start, iv, cout, ordy;
        logic [39:0] sum;
        logic        e_ir, e_ov, e_busy, e_ovf;
        logic [39:0] e_acc;
        int          e_cnt;
    } vec_t;
    vec_t tbl[$];

    // reference model: 0 idle, 1 accumulating, 2 result pending; total kept exact in 64 bits
    int          m_st[2] = '{0, 0};
    int          m_cnt[2] = '{0, 0};
    logic [63:0] m_tot[2] = '{64'd0, 64'd0};
    int          m_n[2] = '{4, 256};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, s, iv, c, input logic [39:0] sm, input logic o,
                                input logic ir, ov, bz, input logic [39:0] acc, input int cnt,
                                input logic ovf);
        vec_t v;
        v.rst = r; v.start = s; v.iv = iv; v.cout = c; v.sum = sm; v.ordy = o;
        v.e_ir = ir; v.e_ov = ov; v.e_busy = bz; v.e_acc = acc; v.e_cnt = cnt; v.e_ovf = ovf;
        return v;
    endfunction

    task automatic set_in(input logic r, s, iv, c, input logic [39:0] sm, input logic o);
        rst = r; start = s; in_valid = iv; cout = c; sum = sm; out_ready = o;
    endtask

    task automatic model_step(input int k, input logic [63:0] smp);
        if (rst) begin
            m_st[k] = 0; m_tot[k] = 0; m_cnt[k] = 0;
        end else if (m_st[k] == 0) begin
            if (start) begin m_st[k] = 1; m_tot[k] = 0; m_cnt[k] = 0; end
        end else if (m_st[k] == 1) begin
            if (start) begin
                m_tot[k] = 0; m_cnt[k] = 0;
            end else if (in_valid) begin
                m_tot[k] = m_tot[k] + smp;
                m_cnt[k]++;
                if (m_cnt[k] == m_n[k]) m_st[k] = 2;
            end
        end else if (out_ready) begin
            m_st[k] = start ? 1 : 0;
            if (start) begin m_tot[k] = 0; m_cnt[k] = 0; end
        end
    endtask

    task automatic chk_post(input int k, input logic ov, bz, input logic [39:0] acc,
                            input logic ovf, input int cnt);
        chk($sformatf("out_valid[%0d]", k), 64'(ov), 64'(m_st[k] == 2));
        chk($sformatf("busy[%0d]", k), 64'(bz), 64'(m_st[k] == 1));
        chk($sformatf("acc_out[%0d]", k), 64'(acc), 64'(m_tot[k][39:0]));
        chk($sformatf("overflow[%0d]", k), 64'(ovf), 64'(|m_tot[k][63:40]));
        chk($sformatf("sample_cnt[%0d]", k), 64'(cnt), 64'(m_cnt[k]));
    endtask

    // called at posedge+1 with inputs already set; checks both instances against the model
    task automatic cycle();
        logic [63:0] smp;
        smp = {31'd0, cout, sum[31:0]};
        #1;
        chk("in_ready[0]", 64'(b4.in_ready), 64'(!rst && m_st[0] == 1 && !start));
        chk("in_ready[1]", 64'(b256.in_ready), 64'(!rst && m_st[1] == 1 && !start));
        @(posedge clk);
        model_step(0, smp);
        model_step(1, smp);
        #1;
        chk_post(0, b4.out_valid, b4.busy, b4.acc_out, b4.overflow, int'(b4.sample_cnt));
        chk_post(1, b256.out_valid, b256.busy, b256.acc_out, b256.overflow, int'(b256.sample_cnt));
    endtask

    initial begin
        logic [39:0] held, big;
        logic [63:0] exp_ovf_acc;
        logic [1:0]  gap;
        set_in(1, 0, 1, 0, 40'd0, 0);
        // reset with in_valid high, then idle
        tbl.push_back(mk(1, 0, 1, 0, 40'd0, 0, 0, 0, 0, 40'd0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 40'd0, 0, 0, 0, 0, 40'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 40'd1, 0, 0, 0, 0, 40'd0, 0, 0));
        // basic run of four unit samples, one stall cycle, then handshake
        tbl.push_back(mk(0, 1, 0, 0, 40'd0, 0, 0, 0, 1, 40'd0, 0, 0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0, 0, 1, 0, 40'd1, 0, 1, i == 4, i != 4, 40'(i), i, 0));
        tbl.push_back(mk(0, 0, 1, 0, 40'd1, 0, 0, 1, 0, 40'd4, 4, 0));
        tbl.push_back(mk(0, 0, 0, 0, 40'd0, 1, 0, 0, 0, 40'd4, 4, 0));
        // carry-out and junk in the headroom byte
        big = 40'hAB_FFFF_FFFF;
        tbl.push_back(mk(0, 1, 0, 0, 40'd0, 0, 0, 0, 1, 40'd0, 0, 0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0, 0, 1, 1, big, 0, 1, i == 4, i != 4,
                             40'(i * 64'h1_FFFF_FFFF), i, 0));
        // start without out_ready is ignored; with out_ready goes straight to a fresh run
        tbl.push_back(mk(0, 1, 0, 0, 40'd0, 0, 0, 1, 0, 40'h7_FFFF_FFFC, 4, 0));
        tbl.push_back(mk(0, 1, 0, 0, 40'd0, 1, 0, 0, 1, 40'd0, 0, 0));
        // restart after two beats drops the concurrent beat
        tbl.push_back(mk(0, 0, 1, 0, 40'd5, 0, 1, 0, 1, 40'd5, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 40'd7, 0, 1, 0, 1, 40'd12, 2, 0));
        tbl.push_back(mk(0, 1, 1, 0, 40'd9, 0, 0, 0, 1, 40'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 40'd9, 0, 1, 0, 1, 40'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 40'd2, 0, 1, 0, 1, 40'd2, 1, 0));
        // reset mid-run, then reset while the result is pending
        tbl.push_back(mk(1, 0, 1, 0, 40'd2, 0, 0, 0, 0, 40'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 40'd0, 0, 0, 0, 1, 40'd0, 0, 0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0, 0, 1, 0, 40'd1, 0, 1, i == 4, i != 4, 40'(i), i, 0));
        tbl.push_back(mk(1, 0, 0, 0, 40'd0, 0, 0, 0, 0, 40'd0, 0, 0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            set_in(tbl[i].rst, tbl[i].start, tbl[i].iv, tbl[i].cout, tbl[i].sum, tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d in_ready", i), 64'(b4.in_ready), 64'(tbl[i].e_ir));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), 64'(b4.out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("vec%0d busy", i), 64'(b4.busy), 64'(tbl[i].e_busy));
            chk($sformatf("vec%0d acc_out", i), 64'(b4.acc_out), 64'(tbl[i].e_acc));
            chk($sformatf("vec%0d sample_cnt", i), 64'(b4.sample_cnt), 64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d overflow", i), 64'(b4.overflow), 64'(tbl[i].e_ovf));
        end

        // 256 maximal samples on the large instance: wraps and raises overflow
        set_in(1, 0, 0, 0, 40'd0, 0); cycle();
        set_in(0, 1, 0, 0, 40'd0, 0); cycle();
        for (int i = 0; i < 256; i++) begin
            set_in(0, 0, 1, 1, 40'h00_FFFF_FFFF, 0);
            cycle();
        end
        exp_ovf_acc = (64'd256 * ((64'd1 << 33) - 64'd1)) & ((64'd1 << 40) - 64'd1);
        chk("ovf256 acc_out", 64'(b256.acc_out), exp_ovf_acc);
        chk("ovf256 overflow", 64'(b256.overflow), 64'd1);
        chk("ovf256 sample_cnt", 64'(b256.sample_cnt), 64'd256);
        chk("ovf256 out_valid", 64'(b256.out_valid), 64'd1);

        // gaps during accumulation, then five cycles of backpressure on the N=4 instance
        set_in(1, 0, 0, 0, 40'd0, 0); cycle();
        set_in(0, 1, 0, 0, 40'd0, 0); cycle();
        for (int i = 0; i < 40 && m_st[0] == 1; i++) begin
            gap = 2'($urandom_range(0, 3));
            set_in(0, 0, gap != 0, 1'($urandom), {$urandom_range(0, 255), $urandom()}, 0);
            cycle();
        end
        chk("bp reached done", 64'(b4.out_valid), 64'd1);
        held = b4.acc_out;
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 1, 0, 40'd3, 0);
            cycle();
            chk("bp acc_out held", 64'(b4.acc_out), 64'(m_tot[0][39:0]));
        end
        chk("bp acc_out stable", 64'(b4.acc_out), 64'(held));
        set_in(0, 0, 0, 0, 40'd0, 1); cycle();
        chk("bp idle after handshake", 64'(b4.out_valid), 64'd0);

        // random traffic: frequent starts first, then long runs for the N=256 instance
        for (int n = 0; n < 4000; n++) begin
            rst       = $urandom_range(0, 499) == 0;
            start     = $urandom_range(0, n < 1500 ? 15 : 599) == 0;
            in_valid  = $urandom_range(0, 3) != 0;
            cout      = 1'($urandom);
            sum       = {8'($urandom), $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'($urandom)};
            out_ready = 1'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
